// File: rtl/mmio_console_if.sv
// rtl/mmio_console_if.sv - data-side request/response bus between the core and mmio_console
// Request fields mirror memory_io_req, response fields mirror memory_io_rsp.
interface mmio_console_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_do_read;
  logic [3:0]  req_do_write;
  logic [7:0]  req_user_tag;

  logic        rsp_valid;
  logic [31:0] rsp_addr;
  logic [31:0] rsp_data;
  logic [7:0]  rsp_user_tag;

  modport master (
    output req_valid, req_addr, req_data, req_do_read, req_do_write, req_user_tag,
    input  rsp_valid, rsp_addr, rsp_data, rsp_user_tag
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_do_read, req_do_write, req_user_tag,
    output rsp_valid, rsp_addr, rsp_data, rsp_user_tag
  );
endinterface

// File: rtl/mmio_console.sv
// rtl/mmio_console.sv - MMIO console/halt responder with TX FIFO, cycle counter and status
// Answers hits in a 256-byte window one cycle later; halt waits for the TX FIFO to drain.
module mmio_console #(
  parameter logic [31:0] BASE_ADDR    = 32'h0002_FF00,
  parameter int          FIFO_DEPTH   = 16,
  parameter bit          RSP_ON_WRITE = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  mmio_console_if.slave bus,
  output logic          tx_valid,
  output logic [7:0]    tx_data,
  input  logic          tx_ready,
  output logic          halt
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  localparam logic [7:0] OFF_STATUS   = 8'hEC;
  localparam logic [7:0] OFF_CYCLE_LO = 8'hF0;
  localparam logic [7:0] OFF_CYCLE_HI = 8'hF4;
  localparam logic [7:0] OFF_TX       = 8'hF8;
  localparam logic [7:0] OFF_HALT     = 8'hFC;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e             state_q;
  logic               halt_q;

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;
  logic [63:0]        cycle_q, cycle_d;
  logic [31:0]        hi_shadow_q, hi_shadow_d;

  logic               rsp_valid_q;
  logic [31:0]        rsp_addr_q;
  logic [31:0]        rsp_data_q;
  logic [7:0]         rsp_tag_q;

  logic               hit;
  logic               is_write;
  logic               rsp_fire;
  logic [7:0]         offset;
  logic               fifo_empty;
  logic               fifo_full;
  logic               pop;
  logic               push_req;
  logic               push;
  logic               drop;
  logic               halt_wr;
  logic               lo_rd;
  logic [31:0]        rd_data;
  logic               unused_req_bits;

  assign unused_req_bits = ^bus.req_data[31:8];

  // Request decode; a request with both read and write strobes counts as a write.
  always_comb begin
    hit      = bus.req_valid
               && (bus.req_addr[31:8] == BASE_ADDR[31:8])
               && ((bus.req_do_read != 4'b0) || (bus.req_do_write != 4'b0));
    is_write = (bus.req_do_write != 4'b0);
    offset   = bus.req_addr[7:0];
    rsp_fire = hit && (!is_write || RSP_ON_WRITE);
    halt_wr  = hit && is_write && (offset == OFF_HALT);
    lo_rd    = hit && !is_write && (offset == OFF_CYCLE_LO);
    push_req = hit && is_write && (offset == OFF_TX) && bus.req_do_write[0];
  end

  // A pop frees the slot in the same edge, so a push against a full FIFO
  // that is also draining this cycle is kept rather than dropped.
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CNT_FULL);
    pop        = !fifo_empty && tx_ready;
    push       = push_req && (!fifo_full || pop);
    drop       = push_req && !push;

    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);

    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end

    cycle_d     = halt_q ? cycle_q : cycle_q + 64'd1;
    hi_shadow_d = lo_rd ? cycle_q[63:32] : hi_shadow_q;
  end

  // Read data is sampled from pre-update state.
  always_comb begin
    rd_data = 32'h0;
    case (offset)
      OFF_TX:       rd_data = {{(32 - CNT_W){1'b0}}, count_q};
      OFF_HALT:     rd_data = {31'h0, (state_q != ST_RUN)};
      OFF_CYCLE_LO: rd_data = cycle_q[31:0];
      OFF_CYCLE_HI: rd_data = hi_shadow_q;
      OFF_STATUS:   rd_data = {16'h0, drop_cnt_q, 6'h0, fifo_empty, fifo_full};
      default:      rd_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.req_data[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      drop_cnt_q  <= 8'h0;
      cycle_q     <= 64'h0;
      hi_shadow_q <= 32'h0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      drop_cnt_q  <= drop_cnt_d;
      cycle_q     <= cycle_d;
      hi_shadow_q <= hi_shadow_d;
    end
  end

  // Halt sequencing: halt only once the request is seen and the FIFO is empty after this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      halt_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (halt_wr) begin
            if (count_d == '0) begin
              state_q <= ST_HALTED;
              halt_q  <= 1'b1;
            end else begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (count_d == '0) begin
            state_q <= ST_HALTED;
            halt_q  <= 1'b1;
          end
        end
        ST_HALTED: begin
          halt_q <= 1'b1;
        end
        default: begin
          state_q <= ST_RUN;
          halt_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= 32'h0;
      rsp_data_q  <= 32'h0;
      rsp_tag_q   <= 8'h0;
    end else begin
      rsp_valid_q <= rsp_fire;
      if (rsp_fire) begin
        rsp_addr_q <= bus.req_addr;
        rsp_tag_q  <= bus.req_user_tag;
        rsp_data_q <= is_write ? 32'h0 : rd_data;
      end
    end
  end

  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_addr     = rsp_addr_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_user_tag = rsp_tag_q;

  assign tx_valid = !fifo_empty;
  assign tx_data  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
  assign halt     = halt_q;
endmodule
